gj_axis_uart_tx_arb: RTL and testbench

//  Frame-level round-robin arbiter sharing one AXI-Stream UART transmitter among NREQ byte-stream sources.

---
 rtl/gj_axis_uart_tx_arb_if.sv | 34 +++
 rtl/gj_axis_uart_tx_arb.sv | 198 +++++++++++++++++++
 tb/tb_gj_axis_uart_tx_arb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/gj_axis_uart_tx_arb_if.sv
// ---------------------------------------------------------------------------
// gj_axis_uart_tx_arb_if
// Bundles the per-source AXI-Stream inputs and the single AXI-Stream output
// of the UART TX arbiter.
//   s_tvalid/s_tdata/s_tlast : NREQ byte-stream sources (source i data in [8i+7:8i])
//   s_tready                 : per-source ready, only the granted bit may be 1
//   m_tvalid/m_tdata/m_tlast : towards the UART TX slave port
//   m_tready                 : from the UART TX
// Modports:
//   slave  : arbiter view (consumes sources, drives the UART side)
//   master : environment view (drives sources and UART ready)
// ---------------------------------------------------------------------------
interface gj_axis_uart_tx_arb_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   s_tvalid;
    logic [NREQ-1:0]   s_tready;
    logic [NREQ*8-1:0] s_tdata;
    logic [NREQ-1:0]   s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [7:0]        m_tdata;
    logic              m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/gj_axis_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// gj_axis_uart_tx_arb
// Frame-level round-robin arbiter sharing one AXI-Stream UART transmitter
// among NREQ byte sources. A grant is held until the tlast beat, optionally
// preceded by a source-ID header byte (HDR_BASE + id). A watchdog drops a
// grant whose source stops presenting data for cfg_stall_to cycles.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg_hdr_en    : emit header byte before each frame (sampled at grant)
//   cfg_stall_to  : watchdog limit in cycles, 0 disables (sampled at grant)
//   axis          : source/UART handshake bundle (slave modport)
//   grant_id      : current or last granted source
//   busy          : high while a frame (header or data) is in progress
//   stall_err     : one-cycle pulse when the watchdog releases a grant
// ---------------------------------------------------------------------------
module gj_axis_uart_tx_arb #(
    parameter int          NREQ     = 4,
    parameter int          IDW      = 3,
    parameter logic [7:0]  HDR_BASE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_hdr_en,
    input  logic [15:0]          cfg_stall_to,
    gj_axis_uart_tx_arb_if.slave axis,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 stall_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [7:0]     hdr_q, hdr_d;
    logic [15:0]    stall_to_q, stall_to_d;
    logic [15:0]    stall_cnt_q, stall_cnt_d;

    logic [NREQ-1:0] above_s;
    logic [NREQ-1:0] req_hi_s;
    logic [IDW-1:0]  idx_hi_s, idx_any_s, hit_idx_s;
    logic            hit_s;
    logic            sel_valid_s, sel_last_s;
    logic [7:0]      sel_data_s;
    logic [NREQ-1:0] s_tready_s;
    logic            m_tvalid_s, m_tlast_s;
    logic [7:0]      m_tdata_s;
    logic            hs_s;
    logic            wd_fire_s;

    function automatic logic [7:0] hdr_byte(input logic [IDW-1:0] id);
        return HDR_BASE + 8'(id);
    endfunction

    // Round-robin pick: lowest requester above last_q, else lowest requester overall
    always_comb begin
        idx_hi_s  = '0;
        idx_any_s = '0;
        above_s   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            above_s[j] = (IDW'(j) > last_q);
        end
        req_hi_s = axis.s_tvalid & above_s;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx_hi_s  = req_hi_s[j]       ? IDW'(j) : idx_hi_s;
            idx_any_s = axis.s_tvalid[j]  ? IDW'(j) : idx_any_s;
        end
        hit_s     = |axis.s_tvalid;
        hit_idx_s = (|req_hi_s) ? idx_hi_s : idx_any_s;
    end

    // Granted-source mux and per-source ready; only the granted bit can be set
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        s_tready_s  = '0;
        for (int j = 0; j < NREQ; j++) begin
            sel_valid_s   = (grant_q == IDW'(j)) ? axis.s_tvalid[j]      : sel_valid_s;
            sel_last_s    = (grant_q == IDW'(j)) ? axis.s_tlast[j]       : sel_last_s;
            sel_data_s    = (grant_q == IDW'(j)) ? axis.s_tdata[j*8 +: 8] : sel_data_s;
            s_tready_s[j] = (state_q == ST_DATA) && (grant_q == IDW'(j)) && axis.m_tready;
        end
    end

    // UART-side outputs: idle zeros, registered header byte, or data pass-through
    always_comb begin
        m_tvalid_s = 1'b0;
        m_tdata_s  = 8'h00;
        m_tlast_s  = 1'b0;
        case (state_q)
            ST_HDR: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = hdr_q;
                m_tlast_s  = 1'b0;
            end
            ST_DATA: begin
                m_tvalid_s = sel_valid_s;
                m_tdata_s  = sel_data_s;
                m_tlast_s  = sel_last_s;
            end
            default: begin
                m_tvalid_s = 1'b0;
                m_tdata_s  = 8'h00;
                m_tlast_s  = 1'b0;
            end
        endcase
    end

    assign hs_s      = m_tvalid_s & axis.m_tready;
    // Fires on the cfg_stall_to-th consecutive cycle without source data
    assign wd_fire_s = (state_q == ST_DATA) && (stall_to_q != 16'd0) && !sel_valid_s &&
                       (stall_cnt_q == (stall_to_q - 16'd1));

    // Frame FSM, grant bookkeeping and stall counter next-state
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        hdr_d       = hdr_q;
        stall_to_d  = stall_to_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    grant_d     = hit_idx_s;
                    hdr_d       = hdr_byte(hit_idx_s);
                    stall_to_d  = cfg_stall_to;
                    stall_cnt_d = 16'd0;
                    state_d     = cfg_hdr_en ? ST_HDR : ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (axis.m_tready) begin
                    stall_cnt_d = 16'd0;
                    state_d     = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (hs_s) begin
                    stall_cnt_d = 16'd0;
                    if (m_tlast_s) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (wd_fire_s) begin
                    // Partial frame is abandoned; no tlast is fabricated
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else if (!sel_valid_s) begin
                    stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
                end else begin
                    stall_cnt_d = stall_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_q resets to NREQ-1 so source 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IDW'(NREQ - 1);
            hdr_q       <= 8'h00;
            stall_to_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hdr_q       <= hdr_d;
            stall_to_q  <= stall_to_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign axis.m_tvalid = m_tvalid_s;
    assign axis.m_tdata  = m_tdata_s;
    assign axis.m_tlast  = m_tlast_s;
    assign axis.s_tready = s_tready_s;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign stall_err     = wd_fire_s;

endmodule

// File: tb/tb_gj_axis_uart_tx_arb.sv
module tb_gj_axis_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_hdr_en;
    logic [15:0]    cfg_stall_to;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           stall_err;

    int n_checks = 0;
    int n_errors = 0;

    gj_axis_uart_tx_arb_if #(.NREQ(NREQ)) bus ();

    gj_axis_uart_tx_arb #(.NREQ(NREQ), .IDW(IDW), .HDR_BASE(8'hA0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_hdr_en   (cfg_hdr_en),
        .cfg_stall_to (cfg_stall_to),
        .axis         (bus),
        .grant_id     (grant_id),
        .busy         (busy),
        .stall_err    (stall_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        hdr;
        logic        e_mv;
        logic [7:0]  e_md;
        logic        e_ml;
        logic [3:0]  e_sr;
        logic [2:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] data, input logic [3:0] last,
                                input logic rdy, input logic hdr, input logic mv, input logic [7:0] md,
                                input logic ml, input logic [3:0] sr, input logic [2:0] gid, input logic bz);
        vec_t v;
        v.vld = vld; v.data = data; v.last = last; v.rdy = rdy; v.hdr = hdr;
        v.e_mv = mv; v.e_md = md; v.e_ml = ml; v.e_sr = sr; v.e_gid = gid; v.e_busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] vld, input logic [31:0] data, input logic [3:0] last, input logic rdy);
        bus.s_tvalid = vld;
        bus.s_tdata  = data;
        bus.s_tlast  = last;
        bus.m_tready = rdy;
    endtask

    localparam logic [31:0] B1 = 32'h31211101;
    localparam logic [31:0] B2 = 32'h32221202;

    logic [7:0] beats [3];
    int         idx;
    logic       rdy_t;
    logic       done;

    initial begin
        rst_n        = 1'b0;
        cfg_hdr_en   = 1'b0;
        cfg_stall_to = 16'd0;
        drive(4'h0, 32'h0, 4'h0, 1'b0);
        #3;
        chk("rst_mvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_mdata",  32'(bus.m_tdata),  32'd0);
        chk("rst_sready", 32'(bus.s_tready), 32'd0);
        chk("rst_gid",    32'(grant_id),     32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_stall",  32'(stall_err),    32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin, 2-byte frames, header off: grants 0,1,2,3,0 with idle gaps
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd0, 1'b0));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 4'h1, 3'd0, 1'b1));
        tbl.push_back(mk(4'hF, B2, 4'hF, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 4'h1, 3'd0, 1'b1));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd0, 1'b0));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 4'h2, 3'd1, 1'b1));
        tbl.push_back(mk(4'hF, B2, 4'hF, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 4'h2, 3'd1, 1'b1));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd1, 1'b0));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 4'h4, 3'd2, 1'b1));
        tbl.push_back(mk(4'hF, B2, 4'hF, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 4'h4, 3'd2, 1'b1));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd2, 1'b0));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 4'h8, 3'd3, 1'b1));
        tbl.push_back(mk(4'hF, B2, 4'hF, 1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 4'h8, 3'd3, 1'b1));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd3, 1'b0));
        tbl.push_back(mk(4'hF, B1, 4'h0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 4'h1, 3'd0, 1'b1));
        tbl.push_back(mk(4'hF, B2, 4'hF, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 4'h1, 3'd0, 1'b1));
        // Header on, source 2 sends 55: A2 then 55, no ready during header
        tbl.push_back(mk(4'h4, 32'h00550000, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 3'd0, 1'b0));
        tbl.push_back(mk(4'h4, 32'h00550000, 4'h4, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 4'h0, 3'd2, 1'b1));
        tbl.push_back(mk(4'h4, 32'h00550000, 4'h4, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 4'h4, 3'd2, 1'b1));
        tbl.push_back(mk(4'h0, 32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 3'd2, 1'b0));
        // Header enable raised mid-frame only affects the following frame
        tbl.push_back(mk(4'h2, 32'h00004100, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd2, 1'b0));
        tbl.push_back(mk(4'h2, 32'h00004100, 4'h0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 4'h2, 3'd1, 1'b1));
        tbl.push_back(mk(4'h2, 32'h00004200, 4'h2, 1'b1, 1'b1, 1'b1, 8'h42, 1'b1, 4'h2, 3'd1, 1'b1));
        tbl.push_back(mk(4'h2, 32'h00004300, 4'h2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 3'd1, 1'b0));
        tbl.push_back(mk(4'h2, 32'h00004300, 4'h2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 4'h0, 3'd1, 1'b1));
        tbl.push_back(mk(4'h2, 32'h00004300, 4'h2, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 4'h0, 3'd1, 1'b1));
        tbl.push_back(mk(4'h2, 32'h00004300, 4'h2, 1'b1, 1'b0, 1'b1, 8'h43, 1'b1, 4'h2, 3'd1, 1'b1));
        tbl.push_back(mk(4'h0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 3'd1, 1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].vld, tbl[r].data, tbl[r].last, tbl[r].rdy);
            cfg_hdr_en = tbl[r].hdr;
            @(negedge clk);
            chk($sformatf("r%0d_mvalid", r), 32'(bus.m_tvalid), 32'(tbl[r].e_mv));
            chk($sformatf("r%0d_mdata", r),  32'(bus.m_tdata),  32'(tbl[r].e_md));
            chk($sformatf("r%0d_mlast", r),  32'(bus.m_tlast),  32'(tbl[r].e_ml));
            chk($sformatf("r%0d_sready", r), 32'(bus.s_tready), 32'(tbl[r].e_sr));
            chk($sformatf("r%0d_gid", r),    32'(grant_id),     32'(tbl[r].e_gid));
            chk($sformatf("r%0d_busy", r),   32'(busy),         32'(tbl[r].e_busy));
            chk($sformatf("r%0d_stall", r),  32'(stall_err),    32'd0);
            cyc_end();
        end

        // Source 1 frame with toggling ready while source 0 waits: no interleaving
        cfg_hdr_en = 1'b0;
        beats[0] = 8'h61; beats[1] = 8'h62; beats[2] = 8'h63;
        drive(4'h2, 32'h00006100, 4'h0, 1'b1);
        @(negedge clk);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        cyc_end();
        idx = 0; rdy_t = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive(4'h3, {16'h0000, beats[idx], 8'h05}, {2'b00, (idx == 2), 1'b0}, rdy_t);
            @(negedge clk);
            chk("t3_gid",     32'(grant_id),       32'd1);
            chk("t3_sready0", 32'(bus.s_tready[0]), 32'd0);
            chk("t3_sready1", 32'(bus.s_tready[1]), 32'(rdy_t));
            chk("t3_mdata",   32'(bus.m_tdata),    32'(beats[idx]));
            if (rdy_t) begin
                done = (idx == 2);
                idx++;
            end
            rdy_t = ~rdy_t;
            cyc_end();
        end
        drive(4'h1, 32'h00000005, 4'h1, 1'b1);
        @(negedge clk);
        chk("t3_gap_busy", 32'(busy), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("t3_g0_gid",    32'(grant_id),     32'd0);
        chk("t3_g0_sready", 32'(bus.s_tready), 32'h1);
        chk("t3_g0_mlast",  32'(bus.m_tlast),  32'd1);
        cyc_end();

        // Watchdog: source 3 stalls after one byte, limit 5
        cfg_stall_to = 16'd5;
        drive(4'h8, 32'h71000000, 4'h0, 1'b1);
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("t4_mdata",  32'(bus.m_tdata),  32'h71);
        chk("t4_sready", 32'(bus.s_tready), 32'h8);
        cyc_end();
        drive(4'h1, 32'h00000081, 4'h1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_c%0d", k), 32'(stall_err), 32'(k == 5));
            chk($sformatf("t4_busy_c%0d", k),  32'(busy),      32'd1);
            chk($sformatf("t4_sr0_c%0d", k),   32'(bus.s_tready[0]), 32'd0);
            cyc_end();
        end
        @(negedge clk);
        chk("t4_after_busy",  32'(busy),      32'd0);
        chk("t4_after_stall", 32'(stall_err), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("t4_next_gid",   32'(grant_id),    32'd0);
        chk("t4_next_mdata", 32'(bus.m_tdata), 32'h81);
        cyc_end();

        // Reset mid-frame on source 1, then source 0 has priority again
        drive(4'h2, 32'h00009100, 4'h0, 1'b0);
        @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("t6_pre_mvalid", 32'(bus.m_tvalid), 32'd1);
        chk("t6_pre_gid",    32'(grant_id),     32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mvalid", 32'(bus.m_tvalid), 32'd0);
        chk("t6_rst_sready", 32'(bus.s_tready), 32'd0);
        chk("t6_rst_busy",   32'(busy),         32'd0);
        chk("t6_rst_gid",    32'(grant_id),     32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cfg_stall_to = 16'd0;
        drive(4'hF, B1, 4'h0, 1'b1);
        @(negedge clk);
        chk("t6_post_busy", 32'(busy), 32'd0);
        cyc_end();
        @(negedge clk);
        chk("t6_post_gid",    32'(grant_id),     32'd0);
        chk("t6_post_sready", 32'(bus.s_tready), 32'h1);
        chk("t6_post_mdata",  32'(bus.m_tdata),  32'h01);
        cyc_end();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
